// File: rtl/dram_wb_arbiter_pkg.sv
// dram_arb_pkg: shared types for the DRAM Wishbone arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT, RESP).
//   TMO_CNT_W   : width of the watchdog counter (DRAM_ARB_TIMEOUT_EN builds).
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Covers TIMEOUT_CYCLES up to 65536.
    localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/dram_wb_arbiter_if.sv
// dram_wb_arbiter_if: requester-side bus of the DRAM arbiter.
//   cyc_i/stb_i/we_i : per-requester cycle, strobe and write enable (bit k = requester k)
//   addr_i/data_i    : packed per-requester address and write data (slice k = requester k)
//   data_o           : read data, broadcast to every requester
//   ack_o            : one-hot acknowledge
// Signal names follow the arbiter's point of view. Modport slave is the arbiter,
// modport master is the requester side.
interface dram_wb_arbiter_if #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned WORD_SIZE   = 256,
    parameter int unsigned ADDR_WIDTH  = 32
);
    logic [NUM_MASTERS-1:0]            cyc_i;
    logic [NUM_MASTERS-1:0]            stb_i;
    logic [NUM_MASTERS-1:0]            we_i;
    logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_i;
    logic [NUM_MASTERS*WORD_SIZE-1:0]  data_i;
    logic [WORD_SIZE-1:0]              data_o;
    logic [NUM_MASTERS-1:0]            ack_o;

    modport master (
        output cyc_i, stb_i, we_i, addr_i, data_i,
        input  data_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, addr_i, data_i,
        output data_o, ack_o
    );
endinterface

// File: rtl/dram_wb_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i   : request vector, one bit per requester
//   last_i  : index of the previous owner; scanning starts at last_i+1 (mod NUM)
//   valid_o : at least one request present
//   index_o : first requesting index found by the scan
module rr_pick #(
    parameter int unsigned NUM   = 2,
    parameter int unsigned IDX_W = $clog2(NUM)
) (
    input  logic [NUM-1:0]   req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);

    always_comb begin
        logic        found;
        int unsigned cand;
        found   = 1'b0;
        cand    = 0;
        index_o = '0;
        // i = NUM wraps back to last_i itself, so a lone persistent requester is re-granted.
        for (int unsigned i = 1; i <= NUM; i++) begin
            cand = (32'(last_i) + i) % NUM;
            if (!found && req_i[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                index_o = cand[IDX_W-1:0];
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/dram_wb_arbiter.sv
// dram_wb_arbiter: round-robin arbiter sharing the DRAM wrapper's single Wishbone port.
//   sys_clk, rst_n   : clock, synchronous active-low reset
//   initialized_i    : wrapper calibration done; no request is issued before it
//   bus (slave)      : requester-side cyc/stb/we/addr/data in, data_o/ack_o out
//   m_cyc_o..m_ack_i : wrapper-side Wishbone port
//   grant_o          : index of the current or last owner
//   timeout_o        : sticky watchdog flag
// Optional feature macro: DRAM_ARB_TIMEOUT_EN (WAIT watchdog of TIMEOUT_CYCLES cycles).
// Without it WAIT is unbounded and timeout_o is tied low.
module dram_wb_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned WORD_SIZE      = 256,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           sys_clk,
    input  logic                           rst_n,
    input  logic                           initialized_i,
    dram_wb_arbiter_if.slave               bus,
    output logic                           m_cyc_o,
    output logic                           m_stb_o,
    output logic                           m_we_o,
    output logic [ADDR_WIDTH-1:0]          m_addr_o,
    output logic [WORD_SIZE-1:0]           m_data_o,
    input  logic [WORD_SIZE-1:0]           m_data_i,
    input  logic                           m_ack_i,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_o,
    output logic                           timeout_o
);

    localparam int unsigned GrantW = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > 2 ** TMO_CNT_W) begin : g_param_check
        $error("dram_wb_arbiter: unsupported parameter value");
    end

    logic [NUM_MASTERS-1:0] w_req;
    logic                   w_pick_valid;
    logic [GrantW-1:0]      w_pick_idx;

    arb_state_t             r_state, w_state_d;
    logic [GrantW-1:0]      r_last, w_last_d;
    logic [GrantW-1:0]      r_grant, w_grant_d;
    logic                   r_m_cyc, w_m_cyc_d;
    logic                   r_m_we, w_m_we_d;
    logic [ADDR_WIDTH-1:0]  r_m_addr, w_m_addr_d;
    logic [WORD_SIZE-1:0]   r_m_data, w_m_data_d;
    logic [WORD_SIZE-1:0]   r_data_o, w_data_o_d;
    logic [NUM_MASTERS-1:0] r_ack, w_ack_d;
`ifdef DRAM_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0]   r_tmo_cnt, w_tmo_cnt_d;
    logic                   r_timeout, w_timeout_d;
`endif

    assign w_req = bus.cyc_i & bus.stb_i;

    rr_pick #(
        .NUM   (NUM_MASTERS),
        .IDX_W (GrantW)
    ) u_rr_pick (
        .req_i   (w_req),
        .last_i  (r_last),
        .valid_o (w_pick_valid),
        .index_o (w_pick_idx)
    );

    always_comb begin
        w_state_d  = r_state;
        w_last_d   = r_last;
        w_grant_d  = r_grant;
        w_m_cyc_d  = r_m_cyc;
        w_m_we_d   = r_m_we;
        w_m_addr_d = r_m_addr;
        w_m_data_d = r_m_data;
        w_data_o_d = r_data_o;
        w_ack_d    = '0;
`ifdef DRAM_ARB_TIMEOUT_EN
        w_tmo_cnt_d = r_tmo_cnt;
        w_timeout_d = r_timeout;
`endif
        case (r_state)
            IDLE: begin
                if (initialized_i && w_pick_valid) begin
                    w_m_cyc_d  = 1'b1;
                    w_m_we_d   = bus.we_i[w_pick_idx];
                    w_m_addr_d = bus.addr_i[int'(w_pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
                    w_m_data_d = bus.data_i[int'(w_pick_idx) * WORD_SIZE +: WORD_SIZE];
                    w_last_d   = w_pick_idx;
                    w_grant_d  = w_pick_idx;
                    w_state_d  = WAIT;
`ifdef DRAM_ARB_TIMEOUT_EN
                    w_tmo_cnt_d = '0;
`endif
                end
            end
            WAIT: begin
                if (m_ack_i) begin
                    w_data_o_d = m_data_i;
                    w_m_cyc_d  = 1'b0;
                    // An owner that abandoned the cycle gets no ack; the access still completed.
                    w_ack_d[r_grant] = bus.cyc_i[r_grant];
                    w_state_d  = RESP;
                end
`ifdef DRAM_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_data_o_d       = '0;
                    w_m_cyc_d        = 1'b0;
                    w_ack_d[r_grant] = 1'b1;
                    w_timeout_d      = 1'b1;
                    w_state_d        = RESP;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt + 1'b1;
                end
`endif
            end
            // Dead cycle lets the owner drop stb before the next arbitration.
            RESP:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_last   <= GrantW'(NUM_MASTERS - 1);
            r_grant  <= '0;
            r_m_cyc  <= 1'b0;
            r_m_we   <= 1'b0;
            r_m_addr <= '0;
            r_m_data <= '0;
            r_data_o <= '0;
            r_ack    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_last   <= w_last_d;
            r_grant  <= w_grant_d;
            r_m_cyc  <= w_m_cyc_d;
            r_m_we   <= w_m_we_d;
            r_m_addr <= w_m_addr_d;
            r_m_data <= w_m_data_d;
            r_data_o <= w_data_o_d;
            r_ack    <= w_ack_d;
        end
    end

`ifdef DRAM_ARB_TIMEOUT_EN
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_cnt_d;
            r_timeout <= w_timeout_d;
        end
    end
    assign timeout_o = r_timeout;
`else
    assign timeout_o = 1'b0;
`endif

    assign m_cyc_o    = r_m_cyc;
    assign m_stb_o    = r_m_cyc;
    assign m_we_o     = r_m_we;
    assign m_addr_o   = r_m_addr;
    assign m_data_o   = r_m_data;
    assign grant_o    = r_grant;
    assign bus.data_o = r_data_o;
    assign bus.ack_o  = r_ack;

endmodule

// File: tb/tb_dram_wb_arbiter.sv
// Self-checking bench for dram_wb_arbiter: directed transactions against a small
// wrapper model; expected grants and acks go into queues checked by a monitor.
module tb_dram_wb_arbiter;

    localparam int unsigned NM = 2;
    localparam int unsigned WS = 256;
    localparam int unsigned AW = 32;
    localparam int unsigned TC = 16;
    localparam int unsigned GW = $clog2(NM);

    localparam logic [WS-1:0] DATA_A =
        256'hAABBCCDDEEFF00112233445566778899AABBCCDDEEFF00112233445566778899;
    localparam logic [WS-1:0] DATA_B =
        256'h0123456789ABCDEF0F1E2D3C4B5A69788796A5B4C3D2E1F0FEDCBA9876543210;
    localparam logic [WS-1:0] WR_RESP = {8{32'hC0FFEE00}};

    logic          sys_clk = 1'b0;
    logic          rst_n;
    logic          initialized_i;
    logic          m_cyc_o, m_stb_o, m_we_o;
    logic [AW-1:0] m_addr_o;
    logic [WS-1:0] m_data_o;
    logic [WS-1:0] m_data_i;
    logic          m_ack_i;
    logic [GW-1:0] grant_o;
    logic          timeout_o;

    dram_wb_arbiter_if #(.NUM_MASTERS(NM), .WORD_SIZE(WS), .ADDR_WIDTH(AW)) bus ();

    dram_wb_arbiter #(
        .NUM_MASTERS    (NM),
        .WORD_SIZE      (WS),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .initialized_i (initialized_i),
        .bus           (bus),
        .m_cyc_o       (m_cyc_o),
        .m_stb_o       (m_stb_o),
        .m_we_o        (m_we_o),
        .m_addr_o      (m_addr_o),
        .m_data_o      (m_data_o),
        .m_data_i      (m_data_i),
        .m_ack_i       (m_ack_i),
        .grant_o       (grant_o),
        .timeout_o     (timeout_o)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [NM-1:0] ack;
        logic [WS-1:0] data;
    } ack_exp_t;

    typedef struct {
        logic [GW-1:0] grant;
        logic [AW-1:0] addr;
        logic          we;
    } gnt_exp_t;

    ack_exp_t ack_q[$];
    gnt_exp_t gnt_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [WS-1:0] got, logic [WS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endfunction

    // Wrapper model: acks model_lat+1 cycles after a request appears.
    logic [WS-1:0] mem [logic [AW-1:0]];
    int  model_lat;
    bit  model_en;

    initial begin
        int wait_cnt;
        wait_cnt = 0;
        m_ack_i  = 1'b0;
        m_data_i = '0;
        forever begin
            @(negedge sys_clk);
            m_ack_i = 1'b0;
            if (rst_n && m_cyc_o && m_stb_o && model_en) begin
                if (wait_cnt >= model_lat) begin
                    m_ack_i  = 1'b1;
                    wait_cnt = 0;
                    if (m_we_o) begin
                        mem[m_addr_o] = m_data_o;
                        m_data_i      = WR_RESP;
                    end else begin
                        m_data_i = mem.exists(m_addr_o) ? mem[m_addr_o] : {8{m_addr_o}};
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every ack pulse and every new wrapper request is checked against the queues.
    initial begin
        ack_exp_t ea;
        gnt_exp_t eg;
        logic     prev_stb;
        prev_stb = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (bus.ack_o != '0) begin
                if (ack_q.size() == 0) begin
                    check("unexpected ack_o", bus.ack_o, '0);
                end else begin
                    ea = ack_q.pop_front();
                    check("ack_o", bus.ack_o, ea.ack);
                    check("data_o", bus.data_o, ea.data);
                end
            end
            if (m_stb_o && !prev_stb) begin
                if (gnt_q.size() == 0) begin
                    check("unexpected m_stb_o", m_stb_o, 1'b0);
                end else begin
                    eg = gnt_q.pop_front();
                    check("grant_o", grant_o, eg.grant);
                    check("m_addr_o", m_addr_o, eg.addr);
                    check("m_we_o", m_we_o, eg.we);
                end
            end
            prev_stb = m_stb_o;
        end
    end

    task automatic set_req(input int k, input bit on, input bit we, input logic [AW-1:0] a,
                           input logic [WS-1:0] d);
        bus.cyc_i[k]             = on;
        bus.stb_i[k]             = on;
        bus.we_i[k]              = we;
        bus.addr_i[k*AW +: AW]   = a;
        bus.data_i[k*WS +: WS]   = d;
    endtask

    task automatic wait_ack(input string name, input int limit, output int cycles);
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge sys_clk);
            #1;
            if (bus.ack_o != '0) begin
                cycles = i;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: ack_o still 0 after %0d cycles, expected a pulse", name, limit);
    endtask

    task automatic wait_stb(input bit level, input string name, input int limit);
        for (int i = 1; i <= limit; i++) begin
            @(posedge sys_clk);
            #1;
            if (m_stb_o == level) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL %s: m_stb_o not %0d within %0d cycles", name, level, limit);
    endtask

    initial begin
        #200us;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  stuck;
        rst_n         = 1'b0;
        initialized_i = 1'b0;
        bus.cyc_i     = '0;
        bus.stb_i     = '0;
        bus.we_i      = '0;
        bus.addr_i    = '0;
        bus.data_i    = '0;
        model_en      = 1'b1;
        model_lat     = 2;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk) rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        check("reset m_cyc_o", m_cyc_o, 1'b0);
        check("reset m_stb_o", m_stb_o, 1'b0);
        check("reset ack_o", bus.ack_o, '0);
        check("reset data_o", bus.data_o, '0);
        check("reset grant_o", grant_o, '0);
        check("reset timeout_o", timeout_o, 1'b0);

        // Held off until initialized, then master 0 writes DATA_A to 0x0.
        gnt_q.push_back('{grant: 0, addr: 32'h0, we: 1'b1});
        ack_q.push_back('{ack: 2'b01, data: WR_RESP});
        @(negedge sys_clk) set_req(0, 1'b1, 1'b1, 32'h0, DATA_A);
        stuck = 1'b0;
        repeat (50) begin
            @(posedge sys_clk);
            #1;
            if (m_stb_o) stuck = 1'b1;
        end
        check("m_stb_o before initialized", stuck, 1'b0);
        @(negedge sys_clk) initialized_i = 1'b1;
        @(posedge sys_clk);
        #1;
        check("m_stb_o one cycle after initialized", m_stb_o, 1'b1);
        wait_ack("write m0", 50, cyc);
        @(negedge sys_clk) set_req(0, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(negedge sys_clk);

        // Master 0 reads it back.
        gnt_q.push_back('{grant: 0, addr: 32'h0, we: 1'b0});
        ack_q.push_back('{ack: 2'b01, data: DATA_A});
        set_req(0, 1'b1, 1'b0, 32'h0, '0);
        wait_ack("read m0", 50, cyc);
        @(negedge sys_clk) set_req(0, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(negedge sys_clk);

        // Master 1 writes DATA_B to 0x40.
        gnt_q.push_back('{grant: 1, addr: 32'h40, we: 1'b1});
        ack_q.push_back('{ack: 2'b10, data: WR_RESP});
        set_req(1, 1'b1, 1'b1, 32'h40, DATA_B);
        wait_ack("write m1", 50, cyc);
        @(negedge sys_clk) set_req(1, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(negedge sys_clk);

        // Both masters read continuously: grants alternate 0,1,0,1,0,1.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                gnt_q.push_back('{grant: 0, addr: 32'h0, we: 1'b0});
                ack_q.push_back('{ack: 2'b01, data: DATA_A});
            end else begin
                gnt_q.push_back('{grant: 1, addr: 32'h40, we: 1'b0});
                ack_q.push_back('{ack: 2'b10, data: DATA_B});
            end
        end
        set_req(0, 1'b1, 1'b0, 32'h0, '0);
        set_req(1, 1'b1, 1'b0, 32'h40, '0);
        for (int i = 0; i < 6; i++) wait_ack("rotation", 50, cyc);
        @(negedge sys_clk);
        set_req(0, 1'b0, 1'b0, 32'h0, '0);
        set_req(1, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(negedge sys_clk);

        // Master 1 abandons its cycle in WAIT: the late ack is swallowed.
        model_lat = 5;
        gnt_q.push_back('{grant: 1, addr: 32'h40, we: 1'b0});
        set_req(1, 1'b1, 1'b0, 32'h40, '0);
        wait_stb(1'b1, "m1 request", 20);
        @(negedge sys_clk) set_req(1, 1'b0, 1'b0, 32'h0, '0);
        wait_stb(1'b0, "m1 completion", 50);
        check("ack_o after dropped cyc", bus.ack_o, '0);
        repeat (3) @(negedge sys_clk);
        model_lat = 2;
        gnt_q.push_back('{grant: 0, addr: 32'h0, we: 1'b0});
        ack_q.push_back('{ack: 2'b01, data: DATA_A});
        set_req(0, 1'b1, 1'b0, 32'h0, '0);
        set_req(1, 1'b1, 1'b0, 32'h40, '0);
        wait_ack("m0 after drop", 50, cyc);
        @(negedge sys_clk);
        set_req(0, 1'b0, 1'b0, 32'h0, '0);
        set_req(1, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(negedge sys_clk);

`ifdef DRAM_ARB_TIMEOUT_EN
        // Wrapper never acks: watchdog fires after TC WAIT cycles.
        check("timeout_o before watchdog", timeout_o, 1'b0);
        model_en = 1'b0;
        gnt_q.push_back('{grant: 0, addr: 32'h80, we: 1'b0});
        ack_q.push_back('{ack: 2'b01, data: '0});
        set_req(0, 1'b1, 1'b0, 32'h80, '0);
        wait_stb(1'b1, "timeout request", 20);
        wait_ack("timeout ack", 100, cyc);
        check("timeout latency", 32'(cyc), 32'(TC));
        @(negedge sys_clk) set_req(0, 1'b0, 1'b0, 32'h0, '0);
        repeat (3) @(negedge sys_clk);
        check("timeout_o sticky", timeout_o, 1'b1);
        model_en = 1'b1;
`else
        check("timeout_o tied low", timeout_o, 1'b0);
`endif

        // Reset while master 1 waits; afterwards master 0 wins first.
        model_en = 1'b0;
        gnt_q.push_back('{grant: 1, addr: 32'h80, we: 1'b0});
        set_req(1, 1'b1, 1'b0, 32'h80, DATA_B);
        wait_stb(1'b1, "pre-reset request", 20);
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'h0, '0);
        @(posedge sys_clk);
        #1;
        check("mid reset m_cyc_o", m_cyc_o, 1'b0);
        check("mid reset m_stb_o", m_stb_o, 1'b0);
        check("mid reset m_addr_o", m_addr_o, '0);
        check("mid reset m_data_o", m_data_o, '0);
        check("mid reset data_o", bus.data_o, '0);
        check("mid reset grant_o", grant_o, '0);
        check("mid reset timeout_o", timeout_o, 1'b0);
        @(negedge sys_clk);
        rst_n    = 1'b1;
        model_en = 1'b1;
        gnt_q.push_back('{grant: 0, addr: 32'h0, we: 1'b0});
        ack_q.push_back('{ack: 2'b01, data: DATA_A});
        wait_ack("post-reset m0", 50, cyc);
        @(negedge sys_clk);
        set_req(0, 1'b0, 1'b0, 32'h0, '0);
        set_req(1, 1'b0, 1'b0, 32'h0, '0);

        repeat (5) @(negedge sys_clk);
        check("pending ack expectations", 32'(ack_q.size()), 32'd0);
        check("pending grant expectations", 32'(gnt_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
